pipelined_control_fsm: RTL and testbench

- Registered, stall-aware successor to the combinational decode-only control unit of the RV32I pipeline.
- Decodes the ID-stage instruction into a control bundle and registers it into the ID/EX boundary.
- Owns a RUN/MULDIV/HALT state machine that stalls fetch/decode during multi-cycle M-extension operations and after EBREAK.
- Every output is fully defined for every opcode; no latches.

---
 rtl/pipelined_control_fsm_pkg.sv | 64 ++++++
 rtl/pipelined_control_fsm_control_decode.sv | 101 ++++++++++
 rtl/pipelined_control_fsm.sv | 148 ++++++++++++++
 tb/tb_pipelined_control_fsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_control_fsm_pkg.sv
// Shared definitions for the registered RV32I control unit: opcodes, instruction fields,
// ALU-op classes, writeback/branch select codes, FSM states and the control bundle.
package pipelined_control_fsm_pkg;

    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam int OpcodeLsb = 0;
    localparam int OpcodeMsb = 6;
    localparam int Funct3Lsb = 12;
    localparam int Funct3Msb = 14;
    localparam int Funct7Lsb = 25;
    localparam int Funct7Msb = 31;
    localparam int EbreakBit = 20;

    localparam logic [6:0] Funct7Mext = 7'b0000001;

    localparam logic [3:0] AluR      = 4'b0000;
    localparam logic [3:0] AluImm    = 4'b0001;
    localparam logic [3:0] AluBranch = 4'b0010;
    localparam logic [3:0] AluLoad   = 4'b0011;
    localparam logic [3:0] AluStore  = 4'b0100;
    localparam logic [3:0] AluJalr   = 4'b0101;
    localparam logic [3:0] AluJal    = 4'b0110;
    localparam logic [3:0] AluAuipc  = 4'b0111;
    localparam logic [3:0] AluLui    = 4'b1000;
    localparam logic [3:0] AluMulDiv = 4'b1001;

    localparam logic [1:0] RegDataPc4   = 2'b00;
    localparam logic [1:0] RegDataPcRel = 2'b01;
    localparam logic [1:0] RegDataAlu   = 2'b10;

    localparam logic [1:0] BrNone = 2'b00;
    localparam logic [1:0] BrCond = 2'b01;
    localparam logic [1:0] BrJal  = 2'b10;
    localparam logic [1:0] BrJalr = 2'b11;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StMulDiv = 2'b01,
        StHalt   = 2'b10
    } state_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic [1:0] reg_data;
        logic [1:0] branch;
    } ctrl_t;

endpackage

// File: rtl/pipelined_control_fsm_control_decode.sv
// Purely combinational decode of one instruction into a control bundle plus class flags.
// M-extension decode is present only when RV32M_EN is defined.
module pipelined_control_fsm_control_decode
    import pipelined_control_fsm_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       bundle,
    output logic        is_muldiv,
    output logic        is_div,
    output logic        is_ebreak,
    output logic        is_illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_inst;

    assign opcode = inst[OpcodeMsb:OpcodeLsb];
    assign funct3 = inst[Funct3Msb:Funct3Lsb];
    assign funct7 = inst[Funct7Msb:Funct7Lsb];
    // Register and immediate fields are consumed downstream, not here.
    assign unused_inst = ^inst;

    always_comb begin
        bundle     = '0;
        is_muldiv  = 1'b0;
        is_div     = 1'b0;
        is_ebreak  = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OpRtype: begin
                bundle.alu_op    = AluR;
                bundle.reg_write = 1'b1;
                bundle.reg_data  = RegDataAlu;
                if (funct7 == Funct7Mext) begin
`ifdef RV32M_EN
                    bundle.alu_op = AluMulDiv;
                    is_muldiv     = 1'b1;
                    is_div        = funct3[2];
`else
                    bundle     = '0;
                    is_illegal = 1'b1;
`endif
                end
            end
            OpImm: begin
                bundle.alu_op    = AluImm;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.reg_data  = RegDataAlu;
            end
            OpBranch: begin
                bundle.alu_op = AluBranch;
                bundle.branch = BrCond;
            end
            OpLoad: begin
                bundle.alu_op     = AluLoad;
                bundle.mem_read   = 1'b1;
                bundle.reg_write  = 1'b1;
                bundle.alu_src    = 1'b1;
                bundle.mem_to_reg = 1'b1;
                bundle.reg_data   = RegDataAlu;
            end
            OpStore: begin
                bundle.alu_op    = AluStore;
                bundle.mem_write = 1'b1;
                bundle.alu_src   = 1'b1;
            end
            OpJalr: begin
                bundle.alu_op    = AluJalr;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.reg_data  = RegDataPc4;
                bundle.branch    = BrJalr;
            end
            OpJal: begin
                bundle.alu_op    = AluJal;
                bundle.reg_write = 1'b1;
                bundle.reg_data  = RegDataPc4;
                bundle.branch    = BrJal;
            end
            OpAuipc: begin
                bundle.alu_op    = AluAuipc;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.reg_data  = RegDataPcRel;
            end
            OpLui: begin
                bundle.alu_op    = AluLui;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.reg_data  = RegDataAlu;
            end
            OpFence: ;
            OpSystem: is_ebreak = (funct3 == 3'b000) && inst[EbreakBit];
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_fsm.sv
// Registered, stall-aware RV32I control unit with RUN/MULDIV/HALT sequencing.
// Define RV32M_EN to enable M-extension decode and multi-cycle MUL/DIV stalls.
module pipelined_control_fsm
    import pipelined_control_fsm_pkg::*;
#(
    parameter int unsigned ALUOP_W    = 4,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        inst,
    input  logic               inst_valid,
    input  logic               flush,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic [1:0]         reg_data,
    output logic [1:0]         branch,
    output logic               ctrl_valid,
    output logic               stall,
    output logic               halted,
    output logic               illegal
);

    state_e state_q, state_d;
    ctrl_t  dec_bundle, bundle_q, bundle_d;
    logic   ctrl_valid_q, ctrl_valid_d;
    logic   illegal_q, illegal_d;
    logic   dec_is_muldiv, dec_is_div, dec_is_ebreak, dec_is_illegal;
    logic   accept;

    pipelined_control_fsm_control_decode u_decode (
        .inst       (inst),
        .bundle     (dec_bundle),
        .is_muldiv  (dec_is_muldiv),
        .is_div     (dec_is_div),
        .is_ebreak  (dec_is_ebreak),
        .is_illegal (dec_is_illegal)
    );

    // Stall is a pure state decode so the IF/ID hold never has a path from inst.
    assign stall  = (state_q != StRun);
    assign accept = inst_valid & ~stall & ~flush;

    always_comb begin
        bundle_d     = '0;
        ctrl_valid_d = 1'b0;
        illegal_d    = 1'b0;
        if (accept) begin
            if (dec_is_illegal) begin
                illegal_d = 1'b1;
            end else begin
                bundle_d     = dec_bundle;
                ctrl_valid_d = 1'b1;
            end
        end
    end

`ifdef RV32M_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_m1;

    assign lat_m1 = dec_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StRun: begin
                if (accept) begin
                    if (dec_is_ebreak) begin
                        state_d = StHalt;
                    end else if (dec_is_muldiv && (lat_m1 != '0)) begin
                        state_d = StMulDiv;
                        cnt_d   = lat_m1;
                    end
                end
            end
            StMulDiv: begin
                if (flush) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StRun;
                    end
                end
            end
            StHalt: ;
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_muldiv;
    assign unused_muldiv = ^{dec_is_muldiv, dec_is_div, MUL_CYCLES, DIV_CYCLES, CNT_W};

    always_comb begin
        state_d = state_q;
        if ((state_q == StRun) && accept && dec_is_ebreak) begin
            state_d = StHalt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            bundle_q     <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bundle_q     <= bundle_d;
            ctrl_valid_q <= ctrl_valid_d;
            illegal_q    <= illegal_d;
        end
    end

    assign alu_op     = ALUOP_W'(bundle_q.alu_op);
    assign mem_read   = bundle_q.mem_read;
    assign mem_write  = bundle_q.mem_write;
    assign reg_write  = bundle_q.reg_write;
    assign alu_src    = bundle_q.alu_src;
    assign mem_to_reg = bundle_q.mem_to_reg;
    assign reg_data   = bundle_q.reg_data;
    assign branch     = bundle_q.branch;
    assign ctrl_valid = ctrl_valid_q;
    assign illegal    = illegal_q;
    assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_pipelined_control_fsm.sv
// Self-checking bench: decode vector table, hand-written stall/halt/reset sequences, and
// randomized traffic against a cycle-level behavioural model of the control unit.
module tb_pipelined_control_fsm;

    localparam int MulCycles = 2;
    localparam int DivCycles = 33;

    localparam logic [31:0] IAdd    = 32'h002081B3;
    localparam logic [31:0] ILw     = 32'h0000A103;
    localparam logic [31:0] IEbreak = 32'h00100073;
    localparam logic [31:0] IMul    = 32'h022081B3;
    localparam logic [31:0] IDiv    = 32'h0220C1B3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu_op;
    logic        mem_read, mem_write, reg_write, alu_src, mem_to_reg;
    logic [1:0]  reg_data, branch;
    logic        ctrl_valid, stall, halted, illegal;
    logic [14:0] dut_o;

    always #5 clk = ~clk;

    pipelined_control_fsm #(
        .ALUOP_W    (4),
        .MUL_CYCLES (MulCycles),
        .DIV_CYCLES (DivCycles),
        .CNT_W      (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .inst_valid (inst_valid),
        .flush      (flush),
        .alu_op     (alu_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_data   (reg_data),
        .branch     (branch),
        .ctrl_valid (ctrl_valid),
        .stall      (stall),
        .halted     (halted),
        .illegal    (illegal)
    );

    assign dut_o = {ctrl_valid, illegal, alu_op, mem_read, mem_write, reg_write, alu_src,
                    mem_to_reg, reg_data, branch};

    int vectors = 0;
    int miscompares = 0;

    // Model state: remaining stall cycles and the sticky halt flag.
    int busy_m = 0;
    bit halted_m = 1'b0;

    typedef struct {
        logic [6:0]  opc;
        logic [12:0] word;
    } dec_rec_t;
    dec_rec_t dec_tab[9];

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        valid;
        logic        flush;
        logic [14:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [12:0] cw(input logic [3:0] a, input logic mr, input logic mw,
                                       input logic rw, input logic as, input logic mtr,
                                       input logic [1:0] rd, input logic [1:0] br);
        return {a, mr, mw, rw, as, mtr, rd, br};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] i, output bit legal,
                                       output logic [12:0] word, output bit ebreak,
                                       output int lat);
        legal = 1'b0;
        word = '0;
        ebreak = 1'b0;
        lat = 0;
        if (i[6:0] == 7'b0001111 || i[6:0] == 7'b1110011) begin
            legal = 1'b1;
            ebreak = (i[6:0] == 7'b1110011) && (i[14:12] == 3'b000) && i[20];
            return;
        end
        foreach (dec_tab[k]) begin
            if (dec_tab[k].opc == i[6:0]) begin
                legal = 1'b1;
                word = dec_tab[k].word;
            end
        end
        if (i[6:0] == 7'b0110011 && i[31:25] == 7'b0000001) begin
`ifdef RV32M_EN
            word[12:9] = 4'b1001;
            lat = i[14] ? DivCycles : MulCycles;
`else
            legal = 1'b0;
            word = '0;
`endif
        end
    endfunction

    // Called just after a rising edge; checks stall before the next edge and the bundle after.
    task automatic step(input logic [31:0] i, input logic v, input logic f);
        bit legal, eb, acc, exp_stall;
        logic [12:0] w;
        int lat;
        logic [14:0] exp_o;
        inst = i;
        inst_valid = v;
        flush = f;
        exp_stall = halted_m || (busy_m > 0);
        #1;
        check("stall", 15'(stall), 15'(exp_stall));
        check("halted", 15'(halted), 15'(halted_m));
        ref_decode(i, legal, w, eb, lat);
        acc = v && !exp_stall && !f;
        exp_o = {acc && legal, acc && !legal, (acc && legal) ? w : 13'b0};
        if (f) busy_m = 0;
        else if (busy_m > 0) busy_m--;
        if (acc && eb) halted_m = 1'b1;
        if (acc && legal && lat > 1) busy_m = lat - 1;
        @(posedge clk);
        #1;
        check("bundle", dut_o, exp_o);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inst_valid = 1'b0;
        flush = 1'b0;
        #1;
        check("rst_async_outputs", dut_o, 15'd0);
        check("rst_async_stall", 15'(stall), 15'd0);
        check("rst_async_halted", 15'(halted), 15'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_held_outputs", {dut_o[14:0]}, 15'd0);
        check("rst_held_stall", 15'({stall, halted}), 15'd0);
        rst_n = 1'b1;
        busy_m = 0;
        halted_m = 1'b0;
    endtask

    initial begin
        logic [6:0] ops[11];
        logic [31:0] ri;
        int n;

        dec_tab[0] = '{7'b0110011, cw(4'd0, 0, 0, 1, 0, 0, 2'b10, 2'b00)};
        dec_tab[1] = '{7'b0010011, cw(4'd1, 0, 0, 1, 1, 0, 2'b10, 2'b00)};
        dec_tab[2] = '{7'b1100011, cw(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b01)};
        dec_tab[3] = '{7'b0000011, cw(4'd3, 1, 0, 1, 1, 1, 2'b10, 2'b00)};
        dec_tab[4] = '{7'b0100011, cw(4'd4, 0, 1, 0, 1, 0, 2'b00, 2'b00)};
        dec_tab[5] = '{7'b1100111, cw(4'd5, 0, 0, 1, 1, 0, 2'b00, 2'b11)};
        dec_tab[6] = '{7'b1101111, cw(4'd6, 0, 0, 1, 0, 0, 2'b00, 2'b10)};
        dec_tab[7] = '{7'b0010111, cw(4'd7, 0, 0, 1, 1, 0, 2'b01, 2'b00)};
        dec_tab[8] = '{7'b0110111, cw(4'd8, 0, 0, 1, 1, 0, 2'b10, 2'b00)};

        vecs.push_back('{"add", IAdd, 1, 0, {2'b10, cw(4'd0, 0, 0, 1, 0, 0, 2'b10, 2'b00)}});
        vecs.push_back('{"sub", 32'h402081B3, 1, 0,
                         {2'b10, cw(4'd0, 0, 0, 1, 0, 0, 2'b10, 2'b00)}});
        vecs.push_back('{"addi", 32'h00500093, 1, 0,
                         {2'b10, cw(4'd1, 0, 0, 1, 1, 0, 2'b10, 2'b00)}});
        vecs.push_back('{"lw", ILw, 1, 0, {2'b10, cw(4'd3, 1, 0, 1, 1, 1, 2'b10, 2'b00)}});
        vecs.push_back('{"sw", 32'h0020A223, 1, 0,
                         {2'b10, cw(4'd4, 0, 1, 0, 1, 0, 2'b00, 2'b00)}});
        vecs.push_back('{"beq", 32'h00208463, 1, 0,
                         {2'b10, cw(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b01)}});
        vecs.push_back('{"jal", 32'h010000EF, 1, 0,
                         {2'b10, cw(4'd6, 0, 0, 1, 0, 0, 2'b00, 2'b10)}});
        vecs.push_back('{"jalr", 32'h000100E7, 1, 0,
                         {2'b10, cw(4'd5, 0, 0, 1, 1, 0, 2'b00, 2'b11)}});
        vecs.push_back('{"auipc", 32'h00001297, 1, 0,
                         {2'b10, cw(4'd7, 0, 0, 1, 1, 0, 2'b01, 2'b00)}});
        vecs.push_back('{"lui", 32'h000012B7, 1, 0,
                         {2'b10, cw(4'd8, 0, 0, 1, 1, 0, 2'b10, 2'b00)}});
        vecs.push_back('{"fence", 32'h0FF0000F, 1, 0, 15'b10_0000000000000});
        vecs.push_back('{"ecall", 32'h00000073, 1, 0, 15'b10_0000000000000});
        vecs.push_back('{"illegal", 32'h0000007F, 1, 0, 15'b01_0000000000000});
        vecs.push_back('{"after_illegal", IAdd, 0, 0, 15'd0});
        vecs.push_back('{"flush_add", IAdd, 1, 1, 15'd0});
        vecs.push_back('{"flush_ebreak", IEbreak, 1, 1, 15'd0});
        vecs.push_back('{"run_after_flush_ebreak", ILw, 1, 0,
                         {2'b10, cw(4'd3, 1, 0, 1, 1, 1, 2'b10, 2'b00)}});
`ifdef RV32M_EN
        vecs.push_back('{"mul", IMul, 1, 0, {2'b10, cw(4'd9, 0, 0, 1, 0, 0, 2'b10, 2'b00)}});
        vecs.push_back('{"mul_stall", IAdd, 1, 0, 15'd0});
        vecs.push_back('{"after_mul", IAdd, 1, 0,
                         {2'b10, cw(4'd0, 0, 0, 1, 0, 0, 2'b10, 2'b00)}});
`else
        vecs.push_back('{"mul_no_m", IMul, 1, 0, 15'b01_0000000000000});
`endif

        #2;
        do_reset();

        foreach (vecs[k]) begin
            step(vecs[k].inst, vecs[k].valid, vecs[k].flush);
            check(vecs[k].name, dut_o, vecs[k].exp);
        end

        // Reset mid-stream (mid-divide when the M extension is present).
`ifdef RV32M_EN
        step(IDiv, 1, 0);
        repeat (3) step(IAdd, 1, 0);
`else
        step(IAdd, 1, 0);
`endif
        do_reset();
        step(IAdd, 1, 0);
        check("add_after_reset", dut_o, {2'b10, cw(4'd0, 0, 0, 1, 0, 0, 2'b10, 2'b00)});

`ifdef RV32M_EN
        step(IDiv, 1, 0);
        check("div_issue", dut_o, {2'b10, cw(4'd9, 0, 0, 1, 0, 0, 2'b10, 2'b00)});
        n = 0;
        for (int k = 0; k < 40 && stall; k++) begin
            n++;
            step(IAdd, 1, 0);
        end
        check("div_stall_cycles", 15'(n), 15'(DivCycles - 1));
        step(IAdd, 1, 0);
        check("issue_after_div", 15'(ctrl_valid), 15'd1);

        step(IDiv, 1, 0);
        for (int k = 1; k < 10; k++) step(IAdd, 1, 0);
        step(IAdd, 1, 1);
        check("flush_div_stall", 15'(stall), 15'd0);
        check("flush_div_valid", 15'(ctrl_valid), 15'd0);
        step(IAdd, 1, 0);
`endif

        // EBREAK holds the pipe through flushes until reset.
        step(IEbreak, 1, 0);
        check("ebreak_bundle", dut_o, 15'b10_0000000000000);
        for (int k = 0; k < 100; k++) step(IAdd, 1, (k % 7) == 3);
        check("halt_persist", 15'({halted, stall, ctrl_valid}), 15'b110);
        do_reset();

        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111,
                7'b1101111, 7'b0010111, 7'b0110111, 7'b0001111, 7'b1110011};
        for (int k = 0; k < 400; k++) begin
            ri = $urandom;
            if ($urandom_range(0, 7) != 0) ri[6:0] = ops[$urandom_range(0, 10)];
            if (ri[6:0] == 7'b0110011 && $urandom_range(0, 2) == 0) ri[31:25] = 7'b0000001;
            if (ri[6:0] == 7'b1110011) ri[20] = 1'b0;
            step(ri, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
